// File: rtl/tpu_acc_pkg.sv
// Shared constants for the accumulator pass controller: FSM encoding,
// pass-count derivation and counter-width helpers.
package tpu_acc_pkg;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_PRELOAD = 3'd1;
    localparam logic [2:0] S_ISSUE   = 3'd2;
    localparam logic [2:0] S_STREAM  = 3'd3;
    localparam logic [2:0] S_DONE    = 3'd4;

    localparam int PERF_W = 32;

    function automatic int calc_num_pass(input int rows, input int pe);
        return rows / pe;
    endfunction

    // Index width that never collapses to zero bits for a single pass.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Width able to hold the value 'limit' itself (counters saturate there).
    function automatic int cnt_w(input int limit);
        return (limit > 0) ? $clog2(limit + 1) : 1;
    endfunction

endpackage

// File: rtl/acc_beat_cnt.sv
// Saturating psum beat counter: clear has priority, counts up to LIMIT and holds.
module acc_beat_cnt
    import tpu_acc_pkg::*;
#(
    parameter int LIMIT = 70,
    parameter int W     = cnt_w(LIMIT)
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic at_lim
);

    logic [W-1:0] cnt;

    assign at_lim = (cnt == W'(LIMIT));

    always_ff @(posedge clk) begin
        if (rst || clr)
            cnt <= '0;
        else if (en && !at_lim)
            cnt <= cnt + 1'b1;
    end

endmodule

// File: rtl/acc_ctrl.sv
// Accumulator pass controller: sequences NUM_PASS systolic-array passes per tile.
// Optional perf counters are built when ACC_CTRL_PERF_EN is defined.
module acc_ctrl
    import tpu_acc_pkg::*;
#(
    parameter  int PE_SIZE        = 14,
    parameter  int WEIGHT_ROW_NUM = 294,
    parameter  int WEIGHT_COL_NUM = 70,
    parameter  int PRELOAD_CYC    = 5,
    localparam int NUM_PASS       = calc_num_pass(WEIGHT_ROW_NUM, PE_SIZE),
    localparam int PASS_W         = idx_w(NUM_PASS)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_i,
    input  logic [PE_SIZE-1:0] psum_en_row_i,
    input  logic               ofmap_ready_i,
    output logic               sa_start_o,
    output logic               acc_first_o,
    output logic               acc_last_o,
    output logic [PASS_W-1:0]  pass_idx_o,
    output logic               busy_o,
    output logic               done_o,
    output logic               err_o
`ifdef ACC_CTRL_PERF_EN
    ,
    output logic [PERF_W-1:0]  perf_busy_o,
    output logic [PERF_W-1:0]  perf_stall_o
`endif
);

    localparam int PRE_W = cnt_w(PRELOAD_CYC);

    logic [2:0]       state, state_n;
    logic [PRE_W-1:0] pre_cnt;
    logic             pre_done;
    logic             last_pass;
    logic             in_pass;
    logic             cnt_clr;
    logic             lead_en, trail_en;
    logic             lead_at_lim, trail_at_lim;
    logic             pass_end;
    logic             err_set;

    assign pre_done  = (PRELOAD_CYC <= 1) || (pre_cnt == PRE_W'(PRELOAD_CYC - 1));
    assign last_pass = (pass_idx_o == PASS_W'(NUM_PASS - 1));
    assign in_pass   = (state == S_ISSUE) || (state == S_STREAM);
    assign cnt_clr   = (state == S_PRELOAD) && pre_done;
    assign lead_en   = in_pass && psum_en_row_i[PE_SIZE-1];
    assign trail_en  = in_pass && psum_en_row_i[0];
    assign pass_end  = (state == S_STREAM) && trail_at_lim;

    assign busy_o = (state != S_IDLE);
    assign done_o = (state == S_DONE);

    // Psum activity outside a pass, or a lead beat beyond the column count.
    assign err_set = (((state == S_IDLE) || (state == S_PRELOAD)) && (|psum_en_row_i))
                   || (psum_en_row_i[PE_SIZE-1] && lead_at_lim);

    acc_beat_cnt #(.LIMIT(WEIGHT_COL_NUM)) u_lead (
        .clk    (clk),
        .rst    (rst),
        .clr    (cnt_clr),
        .en     (lead_en),
        .at_lim (lead_at_lim)
    );

    acc_beat_cnt #(.LIMIT(WEIGHT_COL_NUM)) u_trail (
        .clk    (clk),
        .rst    (rst),
        .clr    (cnt_clr),
        .en     (trail_en),
        .at_lim (trail_at_lim)
    );

    always_comb begin
        state_n    = state;
        sa_start_o = 1'b0;
        case (state)
            S_IDLE:    if (start_i) state_n = S_PRELOAD;
            S_PRELOAD: if (pre_done) state_n = S_ISSUE;
            // The final pass waits for room in the ofmap buffer before kicking the SA.
            S_ISSUE: begin
                if (!last_pass || ofmap_ready_i) begin
                    sa_start_o = 1'b1;
                    state_n    = S_STREAM;
                end
            end
            S_STREAM:  if (trail_at_lim) state_n = last_pass ? S_DONE : S_PRELOAD;
            S_DONE:    state_n = S_IDLE;
            default:   state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            pre_cnt     <= '0;
            pass_idx_o  <= '0;
            acc_first_o <= 1'b0;
            acc_last_o  <= 1'b0;
            err_o       <= 1'b0;
        end else begin
            state <= state_n;

            if ((state == S_PRELOAD) && !pre_done)
                pre_cnt <= pre_cnt + 1'b1;
            else
                pre_cnt <= '0;

            if ((state == S_IDLE) && start_i)
                pass_idx_o <= '0;
            else if (pass_end && !last_pass)
                pass_idx_o <= pass_idx_o + 1'b1;
            else if (state == S_DONE)
                pass_idx_o <= '0;

            // Pass flags latch on ISSUE entry and hold until the pass drains.
            if (cnt_clr) begin
                acc_first_o <= (pass_idx_o == '0);
                acc_last_o  <= last_pass;
            end else if (pass_end) begin
                acc_first_o <= 1'b0;
                acc_last_o  <= 1'b0;
            end

            if (err_set)
                err_o <= 1'b1;
        end
    end

`ifdef ACC_CTRL_PERF_EN
    always_ff @(posedge clk) begin
        if (rst || ((state == S_IDLE) && start_i)) begin
            perf_busy_o  <= '0;
            perf_stall_o <= '0;
        end else begin
            if (busy_o)
                perf_busy_o <= perf_busy_o + 1'b1;
            if ((state == S_ISSUE) && last_pass && !ofmap_ready_i)
                perf_stall_o <= perf_stall_o + 1'b1;
        end
    end
`endif

endmodule
